// File: rtl/clock_pkg.sv
// Shared widths, limits, source indices and alarm state type for the clock scheduler.
// Used by clock_time_scheduler and alarm_fsm.
package clock_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HRS_W = 4;

    localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(59);
    localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(59);
    localparam logic [HRS_W-1:0] HRS_MAX = HRS_W'(11);

    // Request sources; a lower index means a higher service priority.
    localparam int N_SRC    = 6;
    localparam int SRC_TICK = 0;
    localparam int SRC_SEC  = 1;
    localparam int SRC_MIN  = 2;
    localparam int SRC_HRS  = 3;
    localparam int SRC_AL   = 4;
    localparam int SRC_TOG  = 5;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2
    } alarm_state_t;

    function automatic logic [SEC_W-1:0] inc_mod60(input logic [SEC_W-1:0] v);
        return (v == SEC_MAX) ? '0 : v + SEC_W'(1);
    endfunction

    function automatic logic [HRS_W-1:0] inc_mod12(input logic [HRS_W-1:0] v);
        return (v == HRS_MAX) ? '0 : v + HRS_W'(1);
    endfunction

endpackage

// File: rtl/alarm_fsm.sv
// Alarm OFF/ARMED/RINGING state machine. With ALARM_TIMEOUT_EN defined, a ring
// counter returns RINGING to ARMED after RING_SECS serviced ticks.
import clock_pkg::*;

module alarm_fsm #(
    parameter int RING_SECS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         toggle_srv,
    input  logic         tick_srv,
    input  logic         match,
    output alarm_state_t state,
    output logic         al_on,
    output logic         alarm
);

    alarm_state_t state_nx;

`ifdef ALARM_TIMEOUT_EN
    logic [6:0] ring_cnt, ring_cnt_nx, ring_inc;

    assign ring_inc = ring_cnt + 7'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OFF;
            ring_cnt <= '0;
        end else begin
            state    <= state_nx;
            ring_cnt <= ring_cnt_nx;
        end
    end
`else
    // No ring counter in this build; the parameter only keeps the interface uniform.
    logic unused_ring_secs;
    assign unused_ring_secs = (RING_SECS != 0);

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= OFF;
        else       state <= state_nx;
    end
`endif

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
        state_nx = state;
`ifdef ALARM_TIMEOUT_EN
        ring_cnt_nx = ring_cnt;
`endif
        case (state)
            OFF: begin
                if (toggle_srv) state_nx = ARMED;
            end
            ARMED: begin
                if (toggle_srv) begin
                    state_nx = OFF;
                end else if (match) begin
                    state_nx = RINGING;
`ifdef ALARM_TIMEOUT_EN
                    ring_cnt_nx = '0;
`endif
                end
            end
            RINGING: begin
                if (toggle_srv) begin
                    state_nx = OFF;
                end
`ifdef ALARM_TIMEOUT_EN
                else if (tick_srv) begin
                    if (ring_inc == 7'(RING_SECS)) begin
                        state_nx    = ARMED;
                        ring_cnt_nx = '0;
                    end else begin
                        ring_cnt_nx = ring_inc;
                    end
                end
`endif
            end
            default: state_nx = OFF;
        endcase
    end

    assign al_on = (state == ARMED) || (state == RINGING);
    assign alarm = (state == RINGING);

`ifndef ALARM_TIMEOUT_EN
    logic unused_tick;
    assign unused_tick = tick_srv;
`endif

endmodule

// File: rtl/clock_time_scheduler.sv
// Time/alarm register owner: captures tick and button pulses as sticky requests and
// services one per cycle by fixed priority. Optional ALARM_TIMEOUT_EN enables ring auto-stop.
import clock_pkg::*;

module clock_time_scheduler #(
    parameter int RING_SECS = 60,
    parameter int AL_STEP   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_1hz,
    input  logic             sec_adj,
    input  logic             min_adj,
    input  logic             hrs_adj,
    input  logic             al_adj,
    input  logic             al_toggle,
    output logic [SEC_W-1:0] seconds,
    output logic [MIN_W-1:0] minutes,
    output logic [HRS_W-1:0] hours,
    output logic [MIN_W-1:0] al_minutes,
    output logic [HRS_W-1:0] al_hours,
    output logic             al_on,
    output logic             alarm,
    output logic             busy,
    output logic             dropped
);

    logic [N_SRC-1:0] req, pending, pending_nx, grant;
    logic [SEC_W-1:0] sec_nx;
    logic [MIN_W-1:0] min_nx, al_min_nx;
    logic [HRS_W-1:0] hrs_nx, al_hrs_nx;
    logic [MIN_W:0]   al_sum;
    logic             match;
    alarm_state_t     al_state;

    assign req = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz};

    // Isolate the lowest set bit: bit 0 (tick) has the highest priority.
    assign grant      = pending & (~pending + N_SRC'(1));
    assign pending_nx = (pending & ~grant) | req;
    assign busy       = |pending;
    assign al_sum     = {1'b0, al_minutes} + (MIN_W+1)'(AL_STEP);

    always_comb begin
        sec_nx    = seconds;
        min_nx    = minutes;
        hrs_nx    = hours;
        al_min_nx = al_minutes;
        al_hrs_nx = al_hours;
        if (grant[SRC_TICK]) begin
            sec_nx = inc_mod60(seconds);
            if (seconds == SEC_MAX) begin
                min_nx = inc_mod60(minutes);
                if (minutes == MIN_MAX) hrs_nx = inc_mod12(hours);
            end
        end else if (grant[SRC_SEC]) begin
            sec_nx = inc_mod60(seconds);
        end else if (grant[SRC_MIN]) begin
            min_nx = inc_mod60(minutes);
        end else if (grant[SRC_HRS]) begin
            hrs_nx = inc_mod12(hours);
        end else if (grant[SRC_AL]) begin
            if (al_sum >= (MIN_W+1)'(60)) begin
                al_min_nx = MIN_W'(al_sum - (MIN_W+1)'(60));
                al_hrs_nx = inc_mod12(al_hours);
            end else begin
                al_min_nx = al_sum[MIN_W-1:0];
            end
        end
    end

    // Only a tick can ring the alarm; the alarm registers are stable during a tick service.
    assign match = grant[SRC_TICK] && (al_state == ARMED) && (sec_nx == '0)
                   && (min_nx == al_minutes) && (hrs_nx == al_hours);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            dropped    <= 1'b0;
            seconds    <= '0;
            minutes    <= '0;
            hours      <= '0;
            al_minutes <= '0;
            al_hours   <= '0;
        end else begin
            pending    <= pending_nx;
            dropped    <= |(req & pending & ~grant);
            seconds    <= sec_nx;
            minutes    <= min_nx;
            hours      <= hrs_nx;
            al_minutes <= al_min_nx;
            al_hours   <= al_hrs_nx;
        end
    end

    alarm_fsm #(
        .RING_SECS (RING_SECS)
    ) u_alarm_fsm (
        .clk        (clk),
        .reset      (reset),
        .toggle_srv (grant[SRC_TOG]),
        .tick_srv   (grant[SRC_TICK]),
        .match      (match),
        .state      (al_state),
        .al_on      (al_on),
        .alarm      (alarm)
    );

endmodule

// File: tb/tb_clock_time_scheduler.sv
// Scoreboard bench for clock_time_scheduler: a time-in-seconds reference model predicts
// every cycle's outputs; a monitor compares them after each clock edge.
module tb_clock_time_scheduler;

    localparam int RS   = 3;
    localparam int STEP = 10;

    localparam bit [5:0] P_TICK = 6'b000001;
    localparam bit [5:0] P_SEC  = 6'b000010;
    localparam bit [5:0] P_MIN  = 6'b000100;
    localparam bit [5:0] P_HRS  = 6'b001000;
    localparam bit [5:0] P_AL   = 6'b010000;
    localparam bit [5:0] P_TOG  = 6'b100000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tick_1hz = 1'b0, sec_adj = 1'b0, min_adj = 1'b0;
    logic hrs_adj = 1'b0, al_adj = 1'b0, al_toggle = 1'b0;
    logic [5:0] seconds, minutes, al_minutes;
    logic [3:0] hours, al_hours;
    logic       al_on, alarm, busy, dropped;

    always #5 clk = ~clk;

    clock_time_scheduler #(
        .RING_SECS (RS),
        .AL_STEP   (STEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .sec_adj    (sec_adj),
        .min_adj    (min_adj),
        .hrs_adj    (hrs_adj),
        .al_adj     (al_adj),
        .al_toggle  (al_toggle),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .al_minutes (al_minutes),
        .al_hours   (al_hours),
        .al_on      (al_on),
        .alarm      (alarm),
        .busy       (busy),
        .dropped    (dropped)
    );

    typedef struct packed {
        logic [5:0] s;
        logic [5:0] m;
        logic [3:0] h;
        logic [5:0] am;
        logic [3:0] ah;
        logic       on;
        logic       ring;
        logic       busy;
        logic       drop;
    } obs_t;

    obs_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model: time as seconds since 00:00:00 of a 12 h dial, alarm as minutes.
    int       m_tsec  = 0;
    int       m_almin = 0;
    int       m_state = 0;   // 0 off, 1 armed, 2 ringing
    int       m_ring  = 0;
    bit [5:0] m_pend  = '0;
    bit       m_drop  = 1'b0;

    task automatic model_step(input bit [5:0] r, input bit rst);
        int srv;
        int f;
        if (rst) begin
            m_tsec = 0; m_almin = 0; m_state = 0; m_ring = 0; m_pend = '0; m_drop = 1'b0;
            return;
        end
        srv = -1;
        for (int i = 0; i < 6; i++) begin
            if (m_pend[i]) begin
                srv = i;
                break;
            end
        end
        m_drop = 1'b0;
        for (int i = 0; i < 6; i++)
            if (r[i] && m_pend[i] && i != srv) m_drop = 1'b1;
        case (srv)
            0: begin
                m_tsec = (m_tsec + 1) % 43200;
                if (m_state == 2) begin
`ifdef ALARM_TIMEOUT_EN
                    m_ring++;
                    if (m_ring == RS) begin
                        m_state = 1;
                        m_ring  = 0;
                    end
`endif
                end else if (m_state == 1 && m_tsec % 60 == 0 && m_tsec / 60 == m_almin) begin
                    m_state = 2;
                    m_ring  = 0;
                end
            end
            1: begin f = m_tsec % 60;        m_tsec += (f + 1) % 60 - f; end
            2: begin f = (m_tsec / 60) % 60; m_tsec += ((f + 1) % 60 - f) * 60; end
            3: begin f = m_tsec / 3600;      m_tsec += ((f + 1) % 12 - f) * 3600; end
            4: m_almin = (m_almin + STEP) % 720;
            5: m_state = (m_state == 0) ? 1 : 0;
            default: ;
        endcase
        if (srv >= 0) m_pend[srv] = 1'b0;
        m_pend |= r;
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.s    = 6'(m_tsec % 60);
        o.m    = 6'((m_tsec / 60) % 60);
        o.h    = 4'(m_tsec / 3600);
        o.am   = 6'(m_almin % 60);
        o.ah   = 4'(m_almin / 60);
        o.on   = (m_state != 0);
        o.ring = (m_state == 2);
        o.busy = |m_pend;
        o.drop = m_drop;
        return o;
    endfunction

    // One clock of stimulus: drive on the falling edge, predict the post-edge outputs.
    task automatic cycle(input bit [5:0] r, input bit rst);
        @(negedge clk);
        {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, tick_1hz} = r;
        reset = rst;
        model_step(r, rst);
        sb.push_back(model_obs());
    endtask

    initial begin : monitor
        obs_t e;
        obs_t g;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = {seconds, minutes, hours, al_minutes, al_hours, al_on, alarm, busy, dropped};
                total++;
                if (g !== e) begin
                    bad++;
                    $display("FAIL outputs @%0t got %0d:%0d:%0d al=%0d:%0d on=%0b ring=%0b busy=%0b drop=%0b want %0d:%0d:%0d al=%0d:%0d on=%0b ring=%0b busy=%0b drop=%0b",
                             $time, g.h, g.m, g.s, g.ah, g.am, g.on, g.ring, g.busy, g.drop,
                             e.h, e.m, e.s, e.ah, e.am, e.on, e.ring, e.busy, e.drop);
                end
            end
        end
    end

    task automatic preset_ring_setup(input int secs);
        cycle(6'b0, 1'b1);
        cycle(P_TOG, 1'b0);
        cycle(P_AL, 1'b0);
        repeat (9) cycle(P_MIN, 1'b0);
        repeat (secs) cycle(P_SEC, 1'b0);
        repeat (2) cycle(6'b0, 1'b0);
    endtask

    initial begin : stimulus
        bit [5:0] r;
        bit       rst;
        repeat (2) cycle(6'b0, 1'b1);

        // Carry chain from 11:59:59.
        repeat (11) cycle(P_HRS, 1'b0);
        repeat (59) cycle(P_MIN, 1'b0);
        repeat (59) cycle(P_SEC, 1'b0);
        repeat (2) cycle(6'b0, 1'b0);
        cycle(P_TICK, 1'b0);
        repeat (3) cycle(6'b0, 1'b0);

        // Tick, sec_adj and min_adj together.
        cycle(6'b0, 1'b1);
        cycle(P_TICK | P_SEC | P_MIN, 1'b0);
        repeat (4) cycle(6'b0, 1'b0);

        // Coalesced sec_adj behind a tick.
        cycle(P_TICK | P_SEC, 1'b0);
        cycle(P_SEC, 1'b0);
        repeat (4) cycle(6'b0, 1'b0);

        // Alarm minute wrap into hours.
        cycle(6'b0, 1'b1);
        repeat (5) cycle(P_AL, 1'b0);
        cycle(6'b0, 1'b0);
        repeat (2) cycle(P_AL, 1'b0);
        repeat (2) cycle(6'b0, 1'b0);

        // Ring from 00:09:58, several ticks while ringing, then toggle off.
        preset_ring_setup(58);
        repeat (6) begin
            cycle(P_TICK, 1'b0);
            cycle(6'b0, 1'b0);
        end
        cycle(P_TOG, 1'b0);
        repeat (3) cycle(6'b0, 1'b0);

        // Tick and toggle together on the matching second.
        preset_ring_setup(59);
        cycle(P_TICK | P_TOG, 1'b0);
        repeat (3) cycle(6'b0, 1'b0);

        // Reset while ringing with requests pending.
        preset_ring_setup(59);
        cycle(P_TICK, 1'b0);
        cycle(P_SEC | P_AL, 1'b0);
        cycle(6'b0, 1'b1);
        repeat (2) cycle(6'b0, 1'b0);

        // Randomized traffic.
        repeat (3000) begin
            r[0] = ($urandom_range(0, 3) == 0);
            for (int i = 1; i < 6; i++) r[i] = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 599) == 0);
            cycle(r, rst);
        end
        repeat (2) cycle(6'b0, 1'b0);

        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_time_scheduler.md
Name: clock_time_scheduler

Overview:
- Owns the clock's time and alarm registers and sequences every update to them.
- Arbitrates the 1 Hz tick and five debounced button pulses so that no request is lost when events coincide.
- Applies exactly one update per cycle, with carry and wrap handling.
- Runs the alarm on/armed/ringing state machine.
- Feeds hours/minutes/seconds and alarm time to the clock renderer, and alarm state to the buzzer gating and bell overlay.

Parameters:
- RING_SECS, 60, number of serviced 1 Hz ticks the alarm rings before auto-stop (only used with ALARM_TIMEOUT_EN).
- AL_STEP, 10, minutes added to the alarm time per al_adj request.

Ports:
- clk  in  1  system clock (31.5 MHz).
- reset  in  1  reset, synchronous, active-high.
- tick_1hz  in  1  one-cycle pulse, one per second.
- sec_adj  in  1  one-cycle pulse, seconds +1.
- min_adj  in  1  one-cycle pulse, minutes +1.
- hrs_adj  in  1  one-cycle pulse, hours +1.
- al_adj  in  1  one-cycle pulse, alarm time +AL_STEP minutes.
- al_toggle  in  1  one-cycle pulse, alarm enable toggle.
- seconds  out  6  0..59.
- minutes  out  6  0..59.
- hours  out  4  0..11.
- al_minutes  out  6  0..59.
- al_hours  out  4  0..11.
- al_on  out  1  alarm enabled (state ARMED or RINGING).
- alarm  out  1  alarm ringing (state RINGING).
- busy  out  1  at least one request pending.
- dropped  out  1  one-cycle pulse: a request arrived while the same source was already pending.

Behaviour:
- Reset: all outputs 0; pending flags cleared; FSM in OFF; ring counter 0. A reset asserted mid-operation discards all pending requests.
- Pending capture:
  - One sticky flag per source.
  - An input pulse sets its flag at the next clk edge.
  - If the flag is already set and not being serviced that cycle, the pulse is coalesced and dropped pulses for one cycle.
  - A pulse arriving in the same cycle its flag is serviced re-sets the flag and is not counted as a drop.
- Service:
  - Each cycle, the highest-priority pending flag is serviced and cleared, and its register update lands at the same edge.
  - Priority: tick > sec_adj > min_adj > hrs_adj > al_adj > al_toggle.
  - Latency: pulse at edge n -> output changes after edge n+1 when uncontested. Each higher-priority pending request adds one cycle.
- busy = OR of the pending flags.
- Arithmetic:
  - tick: seconds+1. At 59 -> 0 and minutes+1; minutes at 59 -> 0 and hours+1; hours at 11 -> 0. Full carry chain in one cycle.
  - sec_adj / min_adj / hrs_adj: increment only their own field and wrap (59->0, 11->0). No carry.
  - al_adj: al_minutes+AL_STEP. If the sum is >= 60, subtract 60 and set al_hours+1 (11 -> 0).
  - Out-of-range values are unreachable; the implementation never compares with >= to repair them.
- Alarm FSM:
  - States OFF, ARMED, RINGING. al_on = (ARMED|RINGING); alarm = RINGING.
  - OFF --al_toggle serviced--> ARMED.
  - ARMED --al_toggle--> OFF.
  - ARMED --match--> RINGING, ring counter cleared. Match = a tick service whose result is hours==al_hours, minutes==al_minutes, seconds==0.
  - RINGING --al_toggle--> OFF.
  - Consequences: enabling the alarm inside the matching minute does not ring until the next 12 h match. Adjust-button updates never trigger the alarm.
- Simultaneous tick and al_toggle: the tick is serviced first (possible ARMED->RINGING), then the toggle next cycle (RINGING->OFF).

Optional Feature:
- ALARM_TIMEOUT_EN defined: in RINGING, each serviced tick increments the ring counter (7 bits). When it reaches RING_SECS, the FSM returns to ARMED with the counter cleared.
- ALARM_TIMEOUT_EN undefined: RINGING persists until al_toggle, and no counter is instantiated.

Decomposition:
- Package clock_pkg:
  - Widths SEC_W=6, MIN_W=6, HRS_W=4.
  - Constants SEC_MAX=59, MIN_MAX=59, HRS_MAX=11.
  - Enum alarm_state_t {OFF, ARMED, RINGING}.
  - Source index constants for the priority encoder.
- Sub-module alarm_fsm: inputs toggle_srv, tick_srv, match; outputs state, al_on, alarm; holds the optional ring counter.
- The top level holds the pending flags, priority encoder and time arithmetic.

Test Plan:
- Carry chain: preset 11:59:59 via adjust pulses, then one tick -> 00:00:00 two cycles later; busy high for exactly one cycle.
- Coincidence: tick, sec_adj and min_adj in the same cycle at 00:00:00 -> seconds=2, minutes=1 after three service cycles; dropped never asserted.
- Coalesce: two sec_adj pulses while a tick blocks service for both -> one increment only; dropped pulses once.
- Alarm wrap: 5 al_adj pulses, then 2 more from 00:00 -> al_hours=1, al_minutes=10.
- Alarm ring: al_toggle (al_on=1), alarm time 00:10, run ticks from 00:09:58 -> alarm=1 after the tick reaching 00:10:00; al_toggle -> al_on=0, alarm=0.
- Timeout (ALARM_TIMEOUT_EN, RING_SECS=3): after ring start, 3 ticks -> alarm=0, al_on=1; reset asserted while ringing -> all outputs 0 next cycle.
